tp_pattern_sequencer: RTL and testbench
=======================================

Name: tp_pattern_sequencer

Overview:
Frame-synchronous pattern controller that sits directly downstream of the VGA timing generator. It consumes the generator's vsync/hsync/dval and produces registered RGB888 test-pattern data with aligned sync outputs. A host can select a pattern, or the block can auto-cycle through patterns every N frames. Pattern switches only take effect at frame boundaries, so no frame is ever torn.

Parameters:
HACT, 640, active pixels per line; sets the color-bar width (HACT/8).
VACT, 480, active lines per frame; sets the y-counter saturation point.
CB_SHIFT, 5, checkerboard square size is 2^CB_SHIFT pixels.
NUM_MODES, 5, number of valid pattern modes (0..NUM_MODES-1).

Ports:
px_clk  in  1  pixel clock (25 MHz)
sys_rst_n  in  1  asynchronous, active-low reset
enable  in  1  pattern output enable
mode_i  in  3  requested pattern mode
mode_wr  in  1  single-cycle strobe; captures mode_i as the pending mode
auto_cycle  in  1  when high, advance the mode every frames_per_pat frames
frames_per_pat  in  8  frames per pattern in auto mode; 0 is treated as 1
vsync_i  in  1  vsync from the timing generator
hsync_i  in  1  hsync from the timing generator
dval_i  in  1  active-pixel valid from the timing generator
vsync_o  out  1  vsync_i delayed by 1 cycle
hsync_o  out  1  hsync_i delayed by 1 cycle
dval_o  out  1  dval_i delayed by 1 cycle
rdata_o  out  8  red
gdata_o  out  8  green
bdata_o  out  8  blue
mode_o  out  3  mode currently being displayed
running_o  out  1  high while in RUN

Behaviour:
- Reset: all outputs and registers go to 0. The state machine enters IDLE; active mode and pending mode are 0.
- Latency: every output is registered exactly 1 cycle after its inputs. The sync outputs are delayed by the same single cycle, so RGB stays aligned with dval_o.
- Edge detection: a frame starts on the rising edge of vsync_i; a line ends on the falling edge of dval_i.
- x_cnt (11 bits): clears whenever dval_i is 0 and increments on each cycle dval_i is 1. The pattern for a pixel uses x_cnt's value before that increment, so the first active pixel has x=0.
- y_cnt (10 bits): clears on the frame-start edge, increments on each line end, and saturates at VACT-1.
- IDLE: RGB outputs 0; syncs still pass through. enable=1 -> ARM.
- ARM: RGB outputs 0. On frame start -> RUN, and the pending mode is loaded into the active mode.
- RUN: RGB follows the active mode while dval_i=1, and is 0 while dval_i=0. enable=0 -> IDLE immediately, and RGB reads 0 on the next cycle (mid-frame drop is allowed).
- mode_wr: latches mode_i into the pending register and sets the pending flag. A later mode_wr within the same frame overwrites the earlier one.
- At each frame start in RUN, if the pending flag is set: active mode <= pending mode, the flag clears, and frame_cnt <= 0.
- Otherwise, if auto_cycle=1 and frame_cnt == max(frames_per_pat,1)-1: active mode <= (mode+1) mod NUM_MODES and frame_cnt <= 0.
- Otherwise frame_cnt increments.
- If a mode_wr strobe and an auto-advance fall on the same frame start, the pending write wins.
- A mode_wr in the same cycle as the frame-start edge counts as pending for the NEXT frame.
- Modes:
  - 0: black.
  - 1: white (FF,FF,FF).
  - 2: 8 color bars. bar = x_cnt/(HACT/8). Sequence is white, yellow, cyan, green, magenta, red, blue, black, using 8-bit full-scale components.
  - 3: gray ramp, R=G=B=x_cnt[7:0] (wraps every 256 px).
  - 4: checkerboard, white when x_cnt[CB_SHIFT]^y_cnt[CB_SHIFT]=1, else black.
  - 5-7: reserved; output black, and they never appear during auto-cycling.
- mode_o and running_o update in the same cycle the active mode or state changes.

Decomposition:
- Package tp_pkg holds:
  - tp_mode_e enum (TP_BLACK, TP_WHITE, TP_BARS, TP_RAMP, TP_CHECK);
  - seq_state_e enum (IDLE, ARM, RUN);
  - the 8-entry color-bar RGB constant table;
  - the default VGA timing constants (HACT, VACT).
- Sub-module tp_pattern_rom: a combinational mapping from (mode, x, y) to RGB888. The sequencer registers its output.

Test Plan:
- Reset release, enable=1, mode_wr with mode 2 before the first vsync rise -> the first frame shows bars. Pixels 0-79 = FFFFFF, 80-159 = FFFF00, 560-639 = 000000; dval_o trails dval_i by exactly 1 cycle.
- Mode 3 running -> RGB = x_cnt[7:0]: pixel 255 = FFFFFF, pixel 256 = 000000. RGB is 0 whenever dval_o=0.
- Mode 4, CB_SHIFT=5 -> (x=0,y=0) black, (x=32,y=0) white, (x=32,y=32) black.
- auto_cycle=1, frames_per_pat=2, start mode 3 -> mode_o sequence 3,3,4,4,0,0,1 across frame starts. frames_per_pat=0 advances every frame.
- mode_wr with mode 1 at the same frame start as a scheduled auto-advance -> mode 1 is NOT applied at that edge. It applies at the following frame start, which takes priority over any auto-advance due then.
- enable dropped mid-line -> RGB=0 on the next cycle, running_o=0. Re-enable -> stays black until the next vsync rise. sys_rst_n asserted mid-frame -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/tp_pkg.sv
// Shared types and constants for the test-pattern sequencer and its pattern ROM.
// Default geometry matches a 640x480 VGA timing generator.
package tp_pkg;

  localparam int TP_HACT = 640;
  localparam int TP_VACT = 480;

  typedef enum logic [2:0] {
    TP_BLACK = 3'd0,
    TP_WHITE = 3'd1,
    TP_BARS  = 3'd2,
    TP_RAMP  = 3'd3,
    TP_CHECK = 3'd4
  } tp_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } seq_state_e;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][23:0] BAR_RGB = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  function automatic logic [23:0] grey(input logic [7:0] level);
    return {level, level, level};
  endfunction

endpackage

// File: rtl/tp_pattern_rom.sv
// Combinational map from (mode, x, y) to an RGB888 pixel; the caller registers it.
// Reserved modes and bar indices past the eighth bar produce black.
module tp_pattern_rom
  import tp_pkg::*;
#(
  parameter int HACT     = TP_HACT,
  parameter int CB_SHIFT = 5
) (
  input  logic [2:0]  mode,
  input  logic [10:0] x,
  input  logic [9:0]  y,
  output logic [23:0] rgb
);

  localparam logic [10:0] BAR_W = 11'(HACT / 8);

  logic [10:0] bar_full;
  logic [2:0]  bar_idx;
  logic        unused_y;

  // Only the checkerboard bit of y matters.
  assign unused_y = ^y;

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    bar_full = x / BAR_W;
    bar_idx  = (bar_full > 11'd7) ? 3'd7 : bar_full[2:0];
    rgb      = '0;
    case (mode)
      TP_WHITE: rgb = 24'hFFFFFF;
      TP_BARS:  rgb = BAR_RGB[bar_idx];
      TP_RAMP:  rgb = grey(x[7:0]);
      TP_CHECK: rgb = (x[CB_SHIFT] ^ y[CB_SHIFT]) ? 24'hFFFFFF : 24'h000000;
      default:  rgb = '0;
    endcase
  end

endmodule

// File: rtl/tp_pattern_sequencer.sv
// Frame-synchronous test-pattern controller behind the VGA timing generator.
// Mode changes (host writes or auto-cycling) take effect only at vsync rise.
module tp_pattern_sequencer
  import tp_pkg::*;
#(
  parameter int HACT      = TP_HACT,
  parameter int VACT      = TP_VACT,
  parameter int CB_SHIFT  = 5,
  parameter int NUM_MODES = 5
) (
  input  logic       px_clk,
  input  logic       sys_rst_n,
  input  logic       enable,
  input  logic [2:0] mode_i,
  input  logic       mode_wr,
  input  logic       auto_cycle,
  input  logic [7:0] frames_per_pat,
  input  logic       vsync_i,
  input  logic       hsync_i,
  input  logic       dval_i,
  output logic       vsync_o,
  output logic       hsync_o,
  output logic       dval_o,
  output logic [7:0] rdata_o,
  output logic [7:0] gdata_o,
  output logic [7:0] bdata_o,
  output logic [2:0] mode_o,
  output logic       running_o
);

  localparam logic [9:0] Y_MAX = 10'(VACT - 1);

  seq_state_e  state_q, state_d;
  logic [2:0]  mode_q, mode_d;
  logic [2:0]  pend_mode_q, pend_mode_d;
  logic        pend_flag_q, pend_flag_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [10:0] x_cnt_q, x_cnt_d;
  logic [9:0]  y_cnt_q, y_cnt_d;
  logic        vsync_q, hsync_q, dval_q;
  logic [23:0] rgb_q, rgb_d;

  logic        frame_start;
  logic        line_end;
  logic [7:0]  fpp_last;
  logic [3:0]  mode_inc;
  logic [2:0]  mode_auto;
  logic [23:0] rom_rgb;

  // The delayed syncs double as the previous-cycle samples for edge detection.
  assign frame_start = vsync_i & ~vsync_q;
  assign line_end    = dval_q & ~dval_i;
  assign fpp_last    = (frames_per_pat == 8'd0) ? 8'd0 : frames_per_pat - 8'd1;
  assign mode_inc    = {1'b0, mode_q} + 4'd1;
  assign mode_auto   = 3'(mode_inc % NUM_MODES);

  tp_pattern_rom #(
    .HACT     (HACT),
    .CB_SHIFT (CB_SHIFT)
  ) u_rom (
    .mode (mode_q),
    .x    (x_cnt_q),
    .y    (y_cnt_q),
    .rgb  (rom_rgb)
  );

  always_comb begin
    x_cnt_d = dval_i ? x_cnt_q + 11'd1 : 11'd0;
    y_cnt_d = y_cnt_q;
    if (frame_start) begin
      y_cnt_d = '0;
    end else if (line_end && (y_cnt_q != Y_MAX)) begin
      y_cnt_d = y_cnt_q + 10'd1;
    end
    // Gating with enable makes a mid-line drop read black on the very next cycle.
    rgb_d = ((state_q == RUN) && enable && dval_i) ? rom_rgb : '0;
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    pend_mode_d = pend_mode_q;
    pend_flag_d = pend_flag_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE: if (enable) state_d = ARM;
      ARM: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (frame_start) begin
          state_d     = RUN;
          mode_d      = pend_mode_q;
          pend_flag_d = 1'b0;
          frame_cnt_d = '0;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (frame_start) begin
          if (pend_flag_q) begin
            mode_d      = pend_mode_q;
            pend_flag_d = 1'b0;
            frame_cnt_d = '0;
          end else if (auto_cycle && (frame_cnt_q == fpp_last)) begin
            mode_d      = mode_auto;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Evaluated after the frame-start load, so a write on that edge waits a frame.
    if (mode_wr) begin
      pend_mode_d = mode_i;
      pend_flag_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge px_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      pend_mode_q <= '0;
      pend_flag_q <= 1'b0;
      frame_cnt_q <= '0;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      vsync_q     <= 1'b0;
      hsync_q     <= 1'b0;
      dval_q      <= 1'b0;
      rgb_q       <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      pend_mode_q <= pend_mode_d;
      pend_flag_q <= pend_flag_d;
      frame_cnt_q <= frame_cnt_d;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      vsync_q     <= vsync_i;
      hsync_q     <= hsync_i;
      dval_q      <= dval_i;
      rgb_q       <= rgb_d;
    end
  end

  assign vsync_o   = vsync_q;
  assign hsync_o   = hsync_q;
  assign dval_o    = dval_q;
  assign rdata_o   = rgb_q[23:16];
  assign gdata_o   = rgb_q[15:8];
  assign bdata_o   = rgb_q[7:0];
  assign mode_o    = mode_q;
  assign running_o = (state_q == RUN);

endmodule

// File: tb/tb_tp_pattern_sequencer.sv
// Self-checking bench: synthetic timing-generator frames, a frame-level reference
// model of the mode rules, and per-scenario checks against fixed expected pixels.
module tb_tp_pattern_sequencer;

  localparam int HACT   = 640;
  localparam int VACT   = 480;
  localparam int FS_IDX = 2;

  logic       px_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] mode_i = '0;
  logic       mode_wr = 1'b0;
  logic       auto_cycle = 1'b0;
  logic [7:0] frames_per_pat = '0;
  logic       vsync_i = 1'b0;
  logic       hsync_i = 1'b0;
  logic       dval_i = 1'b0;
  logic       vsync_o, hsync_o, dval_o, running_o;
  logic [7:0] rdata_o, gdata_o, bdata_o;
  logic [2:0] mode_o;

  tp_pattern_sequencer dut (
    .px_clk         (px_clk),
    .sys_rst_n      (sys_rst_n),
    .enable         (enable),
    .mode_i         (mode_i),
    .mode_wr        (mode_wr),
    .auto_cycle     (auto_cycle),
    .frames_per_pat (frames_per_pat),
    .vsync_i        (vsync_i),
    .hsync_i        (hsync_i),
    .dval_i         (dval_i),
    .vsync_o        (vsync_o),
    .hsync_o        (hsync_o),
    .dval_o         (dval_o),
    .rdata_o        (rdata_o),
    .gdata_o        (gdata_o),
    .bdata_o        (bdata_o),
    .mode_o         (mode_o),
    .running_o      (running_o)
  );

  always #5 px_clk = ~px_clk;

  typedef struct {
    logic       vs, hs, dv, en, wr;
    logic [2:0] mi;
    int         x, y;
  } stim_t;

  stim_t stim_q[$];
  int    errors = 0;
  int    checks = 0;
  logic  en_level = 1'b1;

  // Reference model: 0 = stopped, 1 = waiting for a frame, 2 = displaying.
  int    m_state, m_mode, m_pend, m_flag, m_cnt;
  logic  m_prev_vs;

  logic [30:0] exp_vec, obs_vec;
  logic [23:0] obs_rgb;

  function automatic logic [23:0] pattern(input int mode, input int x, input int y);
    int yy, bar, v;
    logic [7:0] g;
    yy = (y > VACT - 1) ? VACT - 1 : y;
    case (mode)
      1: return 24'hFFFFFF;
      2: begin
        bar = x / (HACT / 8);
        case (bar)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      3: begin
        v = x % 256;
        g = 8'(v);
        return {g, g, g};
      end
      4: return ((((x / 32) % 2) ^ ((yy / 32) % 2)) != 0) ? 24'hFFFFFF : 24'h000000;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_mode = 0; m_pend = 0; m_flag = 0; m_cnt = 0; m_prev_vs = 1'b0;
  endtask

  task automatic push(input logic vs, input logic hs, input logic dv, input int x, input int y);
    stim_t s;
    s.vs = vs; s.hs = hs; s.dv = dv; s.en = en_level; s.wr = 1'b0; s.mi = '0;
    s.x = x; s.y = y;
    stim_q.push_back(s);
  endtask

  // Porch, vsync pulse, porch, then active lines; the vsync rise is at FS_IDX.
  task automatic build_frame(input int lines, input int px, input int hbl, input int vbl);
    for (int i = 0; i < 2; i++) push(1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < vbl; i++) push(1'b1, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 2; i++) push(1'b0, 1'b0, 1'b0, 0, 0);
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < px; p++) push(1'b0, 1'b0, 1'b1, p, l);
      for (int h = 0; h < hbl; h++) push(1'b0, (h == 1), 1'b0, 0, l);
    end
  endtask

  task automatic set_wr(input int idx, input int mode);
    stim_t s;
    s = stim_q[idx];
    s.wr = 1'b1;
    s.mi = 3'(mode);
    stim_q[idx] = s;
  endtask

  task automatic set_en(input int idx, input logic en);
    stim_t s;
    s = stim_q[idx];
    s.en = en;
    stim_q[idx] = s;
  endtask

  function automatic int find_idx(input int y, input int x);
    foreach (stim_q[i]) if (stim_q[i].dv && stim_q[i].x == x && stim_q[i].y == y) return i;
    return 0;
  endfunction

  // Drives one cycle, advances the model by the frame rules, samples #1 after the edge.
  task automatic drive_cycle(input stim_t s);
    logic        fs;
    logic [23:0] e_rgb;
    int          last;
    vsync_i = s.vs; hsync_i = s.hs; dval_i = s.dv;
    enable = s.en; mode_wr = s.wr; mode_i = s.mi;
    fs = s.vs && !m_prev_vs;
    e_rgb = (m_state == 2 && s.en && s.dv) ? pattern(m_mode, s.x, s.y) : 24'h0;
    if (!s.en) begin
      m_state = 0;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (fs && m_state == 1) begin
      m_state = 2; m_mode = m_pend; m_flag = 0; m_cnt = 0;
    end else if (fs) begin
      last = ((frames_per_pat == 0) ? 1 : int'(frames_per_pat)) - 1;
      if (m_flag != 0) begin
        m_mode = m_pend; m_flag = 0; m_cnt = 0;
      end else if (auto_cycle && m_cnt == last) begin
        m_mode = (m_mode + 1) % 5; m_cnt = 0;
      end else begin
        m_cnt = (m_cnt + 1) % 256;
      end
    end
    if (s.wr) begin
      m_pend = int'(s.mi); m_flag = 1;
    end
    m_prev_vs = s.vs;
    exp_vec = {e_rgb, s.vs, s.hs, s.dv, 3'(m_mode), (m_state == 2)};
    @(posedge px_clk);
    #1;
    obs_rgb = {rdata_o, gdata_o, bdata_o};
    obs_vec = {obs_rgb, vsync_o, hsync_o, dval_o, mode_o, running_o};
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      {vsync_i, hsync_i, dval_i, enable, mode_wr, auto_cycle} = 6'($urandom);
      mode_i = 3'($urandom);
      @(posedge px_clk);
      #1;
      checks++;
      if ({rdata_o, gdata_o, bdata_o, vsync_o, hsync_o, dval_o, mode_o, running_o} !== 31'h0) begin
        errors++;
        $display("FAIL reset_hold cycle=%0d got=%h want=0", i,
                 {rdata_o, gdata_o, bdata_o, vsync_o, hsync_o, dval_o, mode_o, running_o});
      end
    end
    {vsync_i, hsync_i, dval_i, enable, mode_wr, auto_cycle} = '0;
    mode_i = '0;
    model_reset();
    @(negedge px_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic test_bars();
    stim_t s;
    en_level = 1'b1;
    build_frame(3, HACT, 20, 2);
    set_wr(0, 2);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive_cycle(s);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL bars_cycle y=%0d x=%0d got=%h want=%h", s.y, s.x, obs_vec, exp_vec);
      end
      if (s.dv && s.y == 0 && (s.x == 0 || s.x == 79 || s.x == 80 || s.x == 560)) begin
        checks++;
        if (obs_rgb !== ((s.x < 80) ? 24'hFFFFFF : (s.x < 160) ? 24'hFFFF00 : 24'h000000)
            || dval_o !== 1'b1) begin
          errors++;
          $display("FAIL bars_pixel x=%0d got=%h dval_o=%b", s.x, obs_rgb, dval_o);
        end
      end
    end
  endtask

  task automatic test_ramp();
    stim_t s;
    build_frame(1, 300, 6, 2);
    set_wr(0, 3);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive_cycle(s);
      checks++;
      if (obs_vec !== exp_vec || (!dval_o && obs_rgb !== 24'h0)) begin
        errors++;
        $display("FAIL ramp_cycle x=%0d got=%h want=%h", s.x, obs_vec, exp_vec);
      end
      if (s.dv && (s.x == 1 || s.x == 255 || s.x == 256)) begin
        checks++;
        if (obs_rgb !== ((s.x == 1) ? 24'h010101 : (s.x == 255) ? 24'hFFFFFF : 24'h000000)) begin
          errors++;
          $display("FAIL ramp_pixel x=%0d got=%h", s.x, obs_rgb);
        end
      end
    end
  endtask

  task automatic test_checker();
    stim_t s;
    build_frame(34, 40, 4, 2);
    set_wr(0, 4);
    build_frame(486, 1, 2, 2);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive_cycle(s);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL check_cycle y=%0d x=%0d got=%h want=%h", s.y, s.x, obs_vec, exp_vec);
      end
      if (s.dv && s.x == 0 && s.y == 0) begin
        checks++;
        if (obs_rgb !== 24'h000000) begin
          errors++; $display("FAIL check_x0_y0 got=%h want=000000", obs_rgb);
        end
      end
      if (s.dv && s.x == 32 && (s.y == 0 || s.y == 32)) begin
        checks++;
        if (obs_rgb !== ((s.y == 0) ? 24'hFFFFFF : 24'h000000)) begin
          errors++; $display("FAIL check_x32 y=%0d got=%h", s.y, obs_rgb);
        end
      end
      if (s.dv && s.x == 0 && (s.y == 32 || s.y == 485)) begin
        checks++;
        if (obs_rgb !== ((s.y == 32) ? 24'hFFFFFF : 24'h000000)) begin
          errors++; $display("FAIL check_ysat y=%0d got=%h", s.y, obs_rgb);
        end
      end
    end
  endtask

  task automatic test_auto_cycle();
    stim_t s;
    int    k;
    logic [2:0] seen[$];
    logic [2:0] want[10] = '{3'd3, 3'd3, 3'd4, 3'd4, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    auto_cycle = 1'b1;
    for (int f = 0; f < 10; f++) begin
      frames_per_pat = (f < 7) ? 8'd2 : 8'd0;
      build_frame(2, 8, 2, 2);
      if (f == 0) set_wr(0, 3);
      k = 0;
      while (stim_q.size() > 0) begin
        s = stim_q.pop_front();
        drive_cycle(s);
        checks++;
        if (obs_vec !== exp_vec) begin
          errors++;
          $display("FAIL auto_cycle f=%0d k=%0d got=%h want=%h", f, k, obs_vec, exp_vec);
        end
        if (k == FS_IDX) seen.push_back(mode_o);
        k++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (seen[i] !== want[i]) begin
        errors++;
        $display("FAIL auto_seq frame=%0d mode_o=%0d want=%0d", i, seen[i], want[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    int    k;
    logic [2:0] want[4] = '{3'd2, 3'd3, 3'd1, 3'd2};
    auto_cycle = 1'b1;
    frames_per_pat = 8'd0;
    for (int f = 0; f < 4; f++) begin
      build_frame(1, 8, 2, 2);
      if (f == 0) set_wr(0, 2);
      if (f == 1) set_wr(FS_IDX, 1);
      k = 0;
      while (stim_q.size() > 0) begin
        s = stim_q.pop_front();
        drive_cycle(s);
        checks++;
        if (obs_vec !== exp_vec) begin
          errors++;
          $display("FAIL collide_cycle f=%0d k=%0d got=%h want=%h", f, k, obs_vec, exp_vec);
        end
        if (k == FS_IDX) begin
          checks++;
          if (mode_o !== want[f]) begin
            errors++;
            $display("FAIL collide_mode frame=%0d mode_o=%0d want=%0d", f, mode_o, want[f]);
          end
        end
        k++;
      end
    end
    auto_cycle = 1'b0;
  endtask

  task automatic test_enable_drop();
    stim_t s;
    int    a, b;
    build_frame(2, 20, 4, 2);
    set_wr(0, 1);
    a = find_idx(0, 10);
    b = find_idx(1, 3);
    for (int i = a; i < b; i++) set_en(i, 1'b0);
    build_frame(2, 20, 4, 2);
    for (int f = 0; stim_q.size() > 0; f++) begin
      s = stim_q.pop_front();
      drive_cycle(s);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL endrop_cycle n=%0d y=%0d x=%0d got=%h want=%h", f, s.y, s.x, obs_vec, exp_vec);
      end
      if (s.dv && s.y == 0 && (s.x == 9 || s.x == 10) && f < a + 2) begin
        checks++;
        if ({obs_rgb, running_o} !== ((s.x == 9) ? 25'h1FFFFFF : 25'h0)) begin
          errors++;
          $display("FAIL endrop_edge x=%0d rgb=%h running=%b", s.x, obs_rgb, running_o);
        end
      end
      if (s.dv && s.y == 1 && s.x == 5 && f < b + 4) begin
        checks++;
        if ({obs_rgb, running_o} !== 25'h0) begin
          errors++;
          $display("FAIL endrop_rearm rgb=%h running=%b want black/0", obs_rgb, running_o);
        end
      end
      if (s.dv && s.y == 0 && s.x == 0 && f > b) begin
        checks++;
        if ({obs_rgb, running_o} !== 25'h1FFFFFF) begin
          errors++;
          $display("FAIL endrop_resume rgb=%h running=%b want ffffff/1", obs_rgb, running_o);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    stim_t s;
    build_frame(2, 20, 4, 2);
    set_wr(0, 1);
    s = stim_q.pop_front();
    while (!(s.dv && s.x == 5)) begin
      drive_cycle(s);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL arst_pre y=%0d x=%0d got=%h want=%h", s.y, s.x, obs_vec, exp_vec);
      end
      s = stim_q.pop_front();
    end
    drive_cycle(s);
    checks++;
    if (obs_rgb !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL arst_before rgb=%h want ffffff", obs_rgb);
    end
    #2;
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({rdata_o, gdata_o, bdata_o, vsync_o, hsync_o, dval_o, mode_o, running_o} !== 31'h0) begin
      errors++;
      $display("FAIL arst_now got=%h want=0",
               {rdata_o, gdata_o, bdata_o, vsync_o, hsync_o, dval_o, mode_o, running_o});
    end
    stim_q.delete();
    {vsync_i, hsync_i, dval_i, enable, mode_wr} = '0;
    model_reset();
    @(negedge px_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic test_random();
    stim_t s;
    int    n, a, len;
    for (int f = 0; f < 8; f++) begin
      auto_cycle = 1'($urandom_range(0, 1));
      frames_per_pat = 8'($urandom_range(0, 3));
      en_level = 1'b1;
      build_frame($urandom_range(1, 4), $urandom_range(8, 64), $urandom_range(2, 8),
                  $urandom_range(1, 3));
      n = stim_q.size();
      for (int w = 0; w < 2; w++)
        if ($urandom_range(0, 1) == 1) set_wr($urandom_range(0, n - 1), $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom_range(0, n - 1);
        len = $urandom_range(1, 12);
        for (int i = a; i < n && i < a + len; i++) set_en(i, 1'b0);
      end
      while (stim_q.size() > 0) begin
        s = stim_q.pop_front();
        drive_cycle(s);
        checks++;
        if (obs_vec !== exp_vec) begin
          errors++;
          $display("FAIL random f=%0d y=%0d x=%0d got=%h want=%h", f, s.y, s.x, obs_vec, exp_vec);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_bars();
    test_ramp();
    test_checker();
    test_auto_cycle();
    test_back_to_back();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
